// File: rtl/param_req_seq.sv
// param_req_seq: FIFO-buffered read/write command sequencer driving the downstream port block.
// Define PARAM_REQ_SEQ_TIMEOUT_EN to build the read timeout counter and rsp_error path.
module param_req_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_ready,
  output logic                  busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("param_req_seq: illegal FIFO_DEPTH or TIMEOUT");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  logic [ENT_W-1:0]      fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  full_s, empty_s, push_s, pop_s;
  logic [ENT_W-1:0]      head_s;
  logic                  head_write_s;
  logic [ADDR_WIDTH-1:0] head_addr_s;
  logic [DATA_WIDTH-1:0] head_data_s;

  state_t                state_r, state_nxt;
  logic                  mem_write_en_r, mem_write_en_nxt;
  logic                  mem_read_en_r, mem_read_en_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_data_in_r, mem_data_in_nxt;
  logic                  rsp_valid_r, rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] rsp_rdata_r, rsp_rdata_nxt;
`ifdef PARAM_REQ_SEQ_TIMEOUT_EN
  localparam logic [7:0] TMO_C = 8'(TIMEOUT);
  logic                  rsp_error_r, rsp_error_nxt;
  logic [7:0]            tmo_cnt_r, tmo_cnt_nxt;
`endif

  assign full_s       = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty_s      = (count_r == {CNT_W{1'b0}});
  assign push_s       = cmd_valid && !full_s;
  assign head_s       = fifo_mem_r[rd_ptr_r];
  assign head_write_s = head_s[ENT_W-1];
  assign head_addr_s  = head_s[DATA_WIDTH +: ADDR_WIDTH];
  assign head_data_s  = head_s[DATA_WIDTH-1:0];

  // Command FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= {ENT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {cmd_write, cmd_addr, cmd_wdata};
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Next state, strobes and response values; a pop loads the head command into the issue registers
  always_comb begin
    state_nxt        = state_r;
    pop_s            = 1'b0;
    mem_write_en_nxt = 1'b0;
    mem_read_en_nxt  = 1'b0;
    mem_addr_nxt     = mem_addr_r;
    mem_data_in_nxt  = mem_data_in_r;
    rsp_valid_nxt    = rsp_valid_r;
    rsp_rdata_nxt    = rsp_rdata_r;
`ifdef PARAM_REQ_SEQ_TIMEOUT_EN
    rsp_error_nxt    = rsp_error_r;
    tmo_cnt_nxt      = tmo_cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s     = 1'b1;
          state_nxt = ST_ISSUE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_write_en_r) begin
          if (!empty_s) begin
            pop_s     = 1'b1;
            state_nxt = ST_ISSUE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          state_nxt = ST_WAIT;
`ifdef PARAM_REQ_SEQ_TIMEOUT_EN
          tmo_cnt_nxt = 8'd0;
`endif
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          rsp_rdata_nxt = mem_data_out;
          rsp_valid_nxt = 1'b1;
          state_nxt     = ST_RESP;
`ifdef PARAM_REQ_SEQ_TIMEOUT_EN
          rsp_error_nxt = 1'b0;
`endif
        end else begin
`ifdef PARAM_REQ_SEQ_TIMEOUT_EN
          tmo_cnt_nxt = tmo_cnt_r + 8'd1;
          if (tmo_cnt_r + 8'd1 == TMO_C) begin
            rsp_rdata_nxt = {DATA_WIDTH{1'b0}};
            rsp_error_nxt = 1'b1;
            rsp_valid_nxt = 1'b1;
            state_nxt     = ST_RESP;
          end else begin
            state_nxt = ST_WAIT;
          end
`else
          state_nxt = ST_WAIT;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          if (!empty_s) begin
            pop_s     = 1'b1;
            state_nxt = ST_ISSUE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          rsp_valid_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (pop_s) begin
      mem_addr_nxt     = head_addr_s;
      mem_write_en_nxt = head_write_s;
      mem_read_en_nxt  = !head_write_s;
      mem_data_in_nxt  = head_write_s ? head_data_s : mem_data_in_r;
    end else begin
      mem_addr_nxt = mem_addr_nxt;
    end
  end

  // State and registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      mem_write_en_r <= 1'b0;
      mem_read_en_r  <= 1'b0;
      mem_addr_r     <= {ADDR_WIDTH{1'b0}};
      mem_data_in_r  <= {DATA_WIDTH{1'b0}};
      rsp_valid_r    <= 1'b0;
      rsp_rdata_r    <= {DATA_WIDTH{1'b0}};
`ifdef PARAM_REQ_SEQ_TIMEOUT_EN
      rsp_error_r    <= 1'b0;
      tmo_cnt_r      <= 8'd0;
`endif
    end else begin
      state_r        <= state_nxt;
      mem_write_en_r <= mem_write_en_nxt;
      mem_read_en_r  <= mem_read_en_nxt;
      mem_addr_r     <= mem_addr_nxt;
      mem_data_in_r  <= mem_data_in_nxt;
      rsp_valid_r    <= rsp_valid_nxt;
      rsp_rdata_r    <= rsp_rdata_nxt;
`ifdef PARAM_REQ_SEQ_TIMEOUT_EN
      rsp_error_r    <= rsp_error_nxt;
      tmo_cnt_r      <= tmo_cnt_nxt;
`endif
    end
  end

  assign cmd_ready    = !full_s;
  assign busy         = !empty_s || (state_r != ST_IDLE);
  assign mem_write_en = mem_write_en_r;
  assign mem_read_en  = mem_read_en_r;
  assign mem_addr     = mem_addr_r;
  assign mem_data_in  = mem_data_in_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_rdata    = rsp_rdata_r;
`ifdef PARAM_REQ_SEQ_TIMEOUT_EN
  assign rsp_error    = rsp_error_r;
`else
  assign rsp_error    = 1'b0;
`endif

endmodule
